// File: rtl/pes_decoder.sv
// rtl/pes_decoder.sv - buffered 3-to-8 one-hot decoder with a 2-entry FIFO.
// Optional odd-parity check on i is enabled by defining PES_DECODER_PARITY_EN.
module pes_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] i,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dec_cnt
`ifdef PES_DECODER_PARITY_EN
  ,
  input  logic       i_par,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t       state, state_nxt;
  logic [2:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       accept;
  logic       word_ok;
  logic       push;
  logic       pop;

`ifdef PES_DECODER_PARITY_EN
  // Odd parity over {i, i_par} marks a good word; bad words are consumed but never stored.
  assign word_ok = ^{i, i_par};
`else
  assign word_ok = 1'b1;
`endif

  always_comb begin
    in_ready  = en && (state != FULL);
    out_valid = (state != EMPTY);
    accept    = in_valid && in_ready;
    push      = accept && word_ok;
    pop       = en && out_valid && out_ready;
    y         = out_valid ? (8'd1 << mem[rd_ptr]) : 8'd0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:  if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      dec_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (push) begin
        mem[wr_ptr] <= i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        dec_cnt <= dec_cnt + 8'd1;
      end
    end
  end

`ifdef PES_DECODER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= accept && !word_ok;
  end
`endif

endmodule
